// File: rtl/cache_fill_fsm_if.sv
// Bundle of cache-side, memory-side and data/tag-array signals for cache_fill_fsm.
// master = the fill engine; slave = the cache/memory environment around it.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [2:0]        word_index;
  logic [15:0]       fill_data;
  logic              write_tag_array;
`ifdef CACHE_FILL_CWF_EN
  logic              crit_valid;
`endif

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address, write_data_array,
           word_index, fill_data, write_tag_array
`ifdef CACHE_FILL_CWF_EN
    , output crit_valid
`endif
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address, write_data_array,
           word_index, fill_data, write_tag_array
`ifdef CACHE_FILL_CWF_EN
    , input crit_valid
`endif
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: fetches a 16-byte block word by word, then writes the tag.
// Optional critical-word-first ordering is enabled by defining CACHE_FILL_CWF_EN.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16
) (
  input logic              clk,
  input logic              rst_n,
  cache_fill_fsm_if.master bus
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [3:0] LP_WORDS = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] LP_LAST  = 4'(WORDS_PER_BLOCK - 1);

  // Counters and word indices are sized for an 8-word block; the engine accepts any latency >= 1.
  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK != 8) begin : g_badParams
    $error("cache_fill_fsm: unsupported WORDS_PER_BLOCK/MEM_LATENCY");
  end

  state_t            r_state;
  logic [ADDR_W-1:4] r_baseBlk;
  logic [3:0]        r_reqCnt;
  logic [3:0]        r_rcvCnt;
  logic [2:0]        w_reqIdx;
  logic [2:0]        w_wrIdx;
  logic              w_fillActive;
  logic              w_reqActive;
  logic              w_wrActive;
  logic              w_lastWord;
  logic              w_unusedMissLsb;

  assign w_unusedMissLsb = &{1'b0, bus.miss_address[3:0]};

`ifdef CACHE_FILL_CWF_EN
  logic [2:0] r_crit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crit <= 3'd0;
    end else if (r_state == IDLE && bus.miss_detected) begin
      r_crit <= bus.miss_address[3:1];
    end
  end

  assign w_reqIdx       = r_reqCnt[2:0] + r_crit;
  assign w_wrIdx        = r_rcvCnt[2:0] + r_crit;
  assign bus.crit_valid = w_wrActive && (r_rcvCnt == 4'd0);
`else
  assign w_reqIdx = r_reqCnt[2:0];
  assign w_wrIdx  = r_rcvCnt[2:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_baseBlk <= '0;
      r_reqCnt  <= 4'd0;
      r_rcvCnt  <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.miss_detected) begin
            r_baseBlk <= bus.miss_address[ADDR_W-1:4];
            r_reqCnt  <= 4'd0;
            r_rcvCnt  <= 4'd0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (r_reqCnt < LP_WORDS) begin
            r_reqCnt <= r_reqCnt + 4'd1;
          end
          if (bus.memory_data_valid) begin
            r_rcvCnt <= r_rcvCnt + 4'd1;
            if (r_rcvCnt == LP_LAST) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded combinationally so the stall and the array writes line up
  // with the miss and the returning data in the same cycle; reset masks them at once.
  assign w_fillActive = rst_n && (r_state == FILL);
  assign w_reqActive  = w_fillActive && (r_reqCnt < LP_WORDS);
  assign w_wrActive   = w_fillActive && bus.memory_data_valid;
  assign w_lastWord   = w_wrActive && (r_rcvCnt == LP_LAST);

  assign bus.fsm_busy         = w_fillActive || bus.miss_detected;
  assign bus.mem_read_en      = w_reqActive;
  assign bus.memory_address   = w_reqActive ? {r_baseBlk, w_reqIdx, 1'b0} : '0;
  assign bus.write_data_array = w_wrActive;
  assign bus.word_index       = w_wrActive ? w_wrIdx : 3'd0;
  assign bus.fill_data        = bus.memory_data;
  assign bus.write_tag_array  = w_lastWord;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: directed per-cycle vectors, expected events queued up front.
// A negedge monitor pops and compares requests, array writes and tag pulses as the DUT emits them.
module tb_cache_fill_fsm;

  localparam int ADDR_W = 16;
  localparam int MAXC   = 32;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
  } req_t;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_W(ADDR_W)) bus ();

  cache_fill_fsm #(
    .WORDS_PER_BLOCK(8),
    .MEM_LATENCY(4),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  req_t expReq[$];
  wr_t  expWr[$];
  int   expTag[$];
  int   expCrit[$];

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = -1;

  bit          missVec[MAXC];
  logic [15:0] addrVec[MAXC];
  bit          validVec[MAXC];
  logic [15:0] dataVec[MAXC];
  bit          rstVec[MAXC];
  bit          expBusy[MAXC];

  int          retCyc[$];
  logic [15:0] retData[$];

  req_t monReq;
  wr_t  monWr;
  int   monCyc;

  function automatic logic [2:0] critOf(input logic [15:0] addr);
`ifdef CACHE_FILL_CWF_EN
    return addr[3:1];
`else
    return 3'd0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input int at);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: event seen at cycle %0d, expected none", name, at);
  endtask

  // Monitor: every active cycle checks the stall; every emitted event is matched in order.
  always @(negedge clk) begin
    if (cyc >= 0) begin
      checkOutput($sformatf("busy@%0d", cyc), 32'(bus.fsm_busy), 32'(expBusy[cyc]));
    end
    if (bus.mem_read_en === 1'b1) begin
      if (expReq.size() == 0) reportUnexpected("request", cyc);
      else begin
        monReq = expReq.pop_front();
        checkOutput("reqCycle", cyc, monReq.cyc);
        checkOutput($sformatf("reqAddr@%0d", cyc), 32'(bus.memory_address), 32'(monReq.addr));
      end
    end
    if (bus.write_data_array === 1'b1) begin
      if (expWr.size() == 0) reportUnexpected("dataWrite", cyc);
      else begin
        monWr = expWr.pop_front();
        checkOutput("wrCycle", cyc, monWr.cyc);
        checkOutput($sformatf("wordIndex@%0d", cyc), 32'(bus.word_index), 32'(monWr.idx));
        checkOutput($sformatf("fillData@%0d", cyc), 32'(bus.fill_data), 32'(monWr.data));
      end
    end
    if (bus.write_tag_array === 1'b1) begin
      if (expTag.size() == 0) reportUnexpected("tagWrite", cyc);
      else begin
        monCyc = expTag.pop_front();
        checkOutput("tagCycle", cyc, monCyc);
      end
    end
`ifdef CACHE_FILL_CWF_EN
    if (bus.crit_valid === 1'b1) begin
      if (expCrit.size() == 0) reportUnexpected("critValid", cyc);
      else begin
        monCyc = expCrit.pop_front();
        checkOutput("critCycle", cyc, monCyc);
      end
    end
`endif
  end

  task automatic idleInputs();
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = '0;
  endtask

  task automatic clearVectors();
    for (int c = 0; c < MAXC; c++) begin
      missVec[c]  = 1'b0;
      addrVec[c]  = '0;
      validVec[c] = 1'b0;
      dataVec[c]  = '0;
      rstVec[c]   = 1'b0;
      expBusy[c]  = 1'b0;
    end
    retCyc.delete();
    retData.delete();
  endtask

  task automatic setMiss(input int from, input int to, input logic [15:0] addr);
    for (int c = from; c <= to; c++) begin
      missVec[c] = 1'b1;
      addrVec[c] = addr;
    end
  endtask

  task automatic setBusy(input int from, input int to);
    for (int c = from; c <= to; c++) expBusy[c] = 1'b1;
  endtask

  task automatic addReturn(input int c, input logic [15:0] data);
    validVec[c] = 1'b1;
    dataVec[c]  = data;
    retCyc.push_back(c);
    retData.push_back(data);
  endtask

  task automatic pushReqs(input logic [15:0] addr, input int start, input int count);
    req_t       r;
    logic [2:0] idx;
    for (int n = 0; n < count; n++) begin
      idx    = critOf(addr) + 3'(n);
      r.cyc  = start + n;
      r.addr = {addr[15:4], idx, 1'b0};
      expReq.push_back(r);
    end
  endtask

  // Queued returns become expected data-array writes in receive order.
  task automatic pushWrites(input logic [15:0] addr);
    wr_t w;
    for (int n = 0; n < retCyc.size(); n++) begin
      w.cyc  = retCyc[n];
      w.idx  = critOf(addr) + 3'(n);
      w.data = retData[n];
      expWr.push_back(w);
      if (n == 0) expCrit.push_back(retCyc[n]);
    end
    retCyc.delete();
    retData.delete();
  endtask

  task automatic applyStimulus(input string testName, input int n);
    $display("[TB] running %s", testName);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc                   = k;
      rst_n                 = !rstVec[k];
      bus.miss_detected     = missVec[k];
      bus.miss_address      = addrVec[k];
      bus.memory_data_valid = validVec[k];
      bus.memory_data       = dataVec[k];
    end
    @(posedge clk);
    #1;
    cyc   = -1;
    rst_n = 1'b1;
    idleInputs();
    checkOutput({testName, ":reqsLeft"}, expReq.size(), 0);
    checkOutput({testName, ":writesLeft"}, expWr.size(), 0);
    checkOutput({testName, ":tagsLeft"}, expTag.size(), 0);
`ifdef CACHE_FILL_CWF_EN
    checkOutput({testName, ":critLeft"}, expCrit.size(), 0);
`endif
    expReq.delete();
    expWr.delete();
    expTag.delete();
    expCrit.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ":memReadEn"}, 32'(bus.mem_read_en), 0);
    checkOutput({tag, ":memAddr"}, 32'(bus.memory_address), 0);
    checkOutput({tag, ":wrData"}, 32'(bus.write_data_array), 0);
    checkOutput({tag, ":wrTag"}, 32'(bus.write_tag_array), 0);
    checkOutput({tag, ":wordIndex"}, 32'(bus.word_index), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkQuiet("inReset");
    checkOutput("inReset:busy", 32'(bus.fsm_busy), 0);
    bus.miss_detected = 1'b1;
    #1;
    checkOutput("inResetMiss:busy", 32'(bus.fsm_busy), 1);
    checkOutput("inResetMiss:memReadEn", 32'(bus.mem_read_en), 0);
    bus.miss_detected = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkQuiet("afterReset");
    checkOutput("afterReset:busy", 32'(bus.fsm_busy), 0);

    clearVectors();
    setMiss(0, 12, 16'h1236);
    for (int n = 0; n < 8; n++) addReturn(5 + n, 16'hA000 + 16'(n));
    pushReqs(16'h1236, 1, 8);
    pushWrites(16'h1236);
    expTag.push_back(12);
    setBusy(0, 12);
    applyStimulus("basicFill", 16);

    clearVectors();
    setMiss(0, 12, 16'hFFFA);
    for (int n = 0; n < 8; n++) addReturn(5 + n, 16'hB000 + 16'(n));
    pushReqs(16'hFFFA, 1, 8);
    pushWrites(16'hFFFA);
    expTag.push_back(12);
    setBusy(0, 12);
    applyStimulus("addressWrap", 16);

    // Reset lands in cycle 6 with valid high; later stray valids must be ignored.
    clearVectors();
    setMiss(0, 5, 16'h2000);
    addReturn(5, 16'hC000);
    pushReqs(16'h2000, 1, 5);
    pushWrites(16'h2000);
    rstVec[6]   = 1'b1;
    validVec[6] = 1'b1;
    dataVec[6]  = 16'hC001;
    for (int c = 7; c <= 12; c++) begin
      validVec[c] = 1'b1;
      dataVec[c]  = 16'hC100 + 16'(c);
    end
    setBusy(0, 5);
    applyStimulus("resetMidFill", 16);

    clearVectors();
    setMiss(0, 20, 16'h3450);
    addReturn(5, 16'hD000);
    addReturn(6, 16'hD001);
    addReturn(9, 16'hD002);
    addReturn(10, 16'hD003);
    addReturn(11, 16'hD004);
    addReturn(14, 16'hD005);
    addReturn(15, 16'hD006);
    addReturn(20, 16'hD007);
    pushReqs(16'h3450, 1, 8);
    pushWrites(16'h3450);
    expTag.push_back(20);
    setBusy(0, 20);
    applyStimulus("irregularLatency", 24);

    clearVectors();
    setMiss(0, 12, 16'h0040);
    setMiss(13, 25, 16'h0080);
    for (int n = 0; n < 8; n++) addReturn(5 + n, 16'hE000 + 16'(n));
    pushReqs(16'h0040, 1, 8);
    pushWrites(16'h0040);
    expTag.push_back(12);
    for (int n = 0; n < 8; n++) addReturn(18 + n, 16'hF000 + 16'(n));
    pushReqs(16'h0080, 14, 8);
    pushWrites(16'h0080);
    expTag.push_back(25);
    setBusy(0, 25);
    applyStimulus("backToBack", 28);

    clearVectors();
    setMiss(0, 12, 16'h123A);
    for (int n = 0; n < 8; n++) addReturn(5 + n, 16'h5000 + 16'(n));
    pushReqs(16'h123A, 1, 8);
    pushWrites(16'h123A);
    expTag.push_back(12);
    setBusy(0, 12);
    applyStimulus("criticalWordMiss", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling engine between the L1 instruction/data memory arrays and the multi-cycle main memory.
- On a cache miss it fetches the enclosing 16-byte block from a pipelined 4-cycle-latency memory and writes each word into the cache data array.
- It then writes the tag array once and releases the stall.
- The CPU pipeline stalls on fsm_busy.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (block = 16 bytes, byte-addressed).
- MEM_LATENCY, 4, cycles from a request on memory_address to memory_data_valid for that request.
- ADDR_W, 16, address width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- miss_detected  input  1  cache reports a miss this cycle (level; held by the cache until the fill completes).
- miss_address  input  ADDR_W  byte address that missed.
- memory_data_valid  input  1  memory returns one word this cycle.
- memory_data  input  16  returned word.
- fsm_busy  output  1  stall request to the pipeline.
- mem_read_en  output  1  memory request strobe.
- memory_address  output  ADDR_W  request address, valid when mem_read_en=1.
- write_data_array  output  1  write fill_data into the data array at word_index.
- word_index  output  3  word offset within the block for the current data-array write.
- fill_data  output  16  word to write; equals memory_data.
- write_tag_array  output  1  one-cycle pulse to write the block tag and set valid.

Behaviour:
- States: IDLE, FILL.
- Registers: base[ADDR_W-1:0], req_cnt[3:0], rcv_cnt[3:0].
- Reset (rst_n=0 at a clock edge): state=IDLE, req_cnt=0, rcv_cnt=0, base=0.
- Outputs during and after reset: fsm_busy=0 (unless miss_detected is high), mem_read_en=0, write_data_array=0, write_tag_array=0, word_index=0, memory_address=0.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the pipeline stalls on the miss cycle itself).
  - On miss_detected=1: base <= {miss_address[15:4],4'h0}, req_cnt<=0, rcv_cnt<=0, next state FILL.
  - memory_data_valid is ignored in IDLE.
- FILL:
  - fsm_busy=1.
  - mem_read_en=1 while req_cnt<8; memory_address = base + 2*req_cnt; req_cnt increments each such cycle.
  - The 8 requests therefore issue back-to-back in FILL cycles 1..8. miss_address and miss_detected changes are ignored.
  - On memory_data_valid=1: write_data_array=1, word_index=rcv_cnt[2:0], fill_data=memory_data; rcv_cnt increments.
  - On memory_data_valid=1 with rcv_cnt==7:
    - write_tag_array=1 in the same cycle.
    - Next state IDLE; fsm_busy remains 1 in this cycle.
    - fsm_busy is 0 in the following cycle unless miss_detected is high again.
- Timing with MEM_LATENCY=4: miss seen at cycle 0; requests at cycles 1-8; data at cycles 5-12; tag pulse at cycle 12; IDLE at cycle 13. Total stall is 13 cycles.
- Request issue and data receipt overlap freely. Requests never wait on returns.
- Data is accepted whenever valid arrives, so the block tolerates memory latency greater than MEM_LATENCY. Valid arriving before all requests have issued is also legal.
- Word ordering: returns are in request order; word_index is the receive count.
- Address arithmetic is modulo 2^ADDR_W. Block 0xFFF0 requests 0xFFF0..0xFFFE with no carry out.
- Reset mid-FILL: abort immediately to IDLE and clear the counters; no tag write is issued.
  - Main memory shares rst_n and drops in-flight requests.
- Back-to-back misses: a miss asserted in the cycle after the tag pulse starts a new fill with no gap beyond that one IDLE cycle.

Optional Feature:
- Macro: CACHE_FILL_CWF_EN (critical word first).
- Defined:
  - Latch crit = miss_address[3:1] on miss acceptance.
  - Request n uses address base + 2*((crit+n) mod 8); word_index = (crit+rcv_cnt) mod 8.
  - Adds output crit_valid, a 1-cycle pulse when the first word (the missed word) is written.
- Undefined: requests start at word 0, crit_valid is absent, and behaviour is exactly as above.

Test Plan:
- Reset then miss_address=0x1236 held, memory returning 0xA000+n at 4-cycle latency:
  - memory_address 0x1230,0x1232..0x123E in cycles 1-8.
  - word_index 0..7 with data 0xA000..0xA007 in cycles 5-12.
  - write_tag_array pulse at cycle 12 only; fsm_busy high in cycles 0-12.
- Address wrap: miss_address=0xFFFA -> requests 0xFFF0..0xFFFE, no 0x0000 request, 8 data writes, 1 tag pulse.
- Reset mid-fill: assert rst_n=0 at cycle 6, then release:
  - Next cycle state IDLE, no outputs asserted.
  - Stray memory_data_valid in cycles 7-12 produce no writes and no tag pulse.
- Irregular latency: valid returns at cycles 5,6,9,10,11,14,15,20 -> 8 data writes with word_index 0..7, tag pulse at cycle 20, fsm_busy drops at cycle 21.
- Back-to-back misses 0x0040 then 0x0080 (the second asserted right after the first tag pulse) -> second request burst starts 2 cycles after the first tag pulse, 0x0080..0x008E.
- With CACHE_FILL_CWF_EN: miss_address=0x123A:
  - Requests 0x123A,0x123C,0x123E,0x1230..0x1238.
  - word_index sequence 5,6,7,0,1,2,3,4; crit_valid pulse at cycle 5.
